// File: rtl/cw_sequencer.sv
// Control-word sequencer: fetches an instruction, then steps it through the decoder bank,
// unpacking each returned control word into gated datapath strobes until the instruction retires.
module cw_sequencer #(
    parameter int MAX_STEPS = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] I,
    output logic [1:0]  state,
    output logic [4:0]  status,
    input  logic [32:0] cw_in,
    input  logic [63:0] K_in,
    input  logic [4:0]  alu_flags,
    input  logic        stall,
    output logic        alu_en,
    output logic        alu_bs,
    output logic        rf_b_en,
    output logic        rf_w,
    output logic        ram_en,
    output logic        ram_w,
    output logic        pc_en,
    output logic        pc_is,
    output logic        status_ld,
    output logic [4:0]  alu_fs,
    output logic [4:0]  rf_sa,
    output logic [4:0]  rf_sb,
    output logic [4:0]  rf_da,
    output logic [1:0]  pc_fs,
    output logic [63:0] K,
    output logic        retire,
    output logic        fault
);

    localparam int SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(MAX_STEPS - 1);

    typedef enum logic [1:0] {
        PH_FETCH = 2'b00,
        PH_EXEC  = 2'b01,
        PH_HALT  = 2'b10
    } phase_t;

    // Field order mirrors the decoder's control-word bit layout, MSB first.
    typedef struct packed {
        logic       alu_en;
        logic       alu_bs;
        logic [4:0] alu_fs;
        logic       rf_b_en;
        logic [4:0] rf_sa;
        logic [4:0] rf_sb;
        logic [4:0] rf_da;
        logic       rf_w;
        logic       ram_en;
        logic       ram_w;
        logic       pc_en;
        logic [1:0] pc_fs;
        logic       pc_is;
        logic       status_ld;
        logic [1:0] next_state;
    } cw_t;

    phase_t        phase_q, phase_d;
    logic [31:0]   i_q, i_d;
    logic [1:0]    state_q, state_d;
    logic [4:0]    status_q, status_d;
    logic          fault_q, fault_d;
    logic [SW-1:0] step_q, step_d;
    cw_t           cw_s;
    logic          write_ok_s;

    assign cw_s = cw_t'(cw_in);

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q  <= PH_FETCH;
            i_q      <= 32'h0000_0000;
            state_q  <= 2'b00;
            status_q <= 5'b00000;
            fault_q  <= 1'b0;
            step_q   <= '0;
        end else begin
            phase_q  <= phase_d;
            i_q      <= i_d;
            state_q  <= state_d;
            status_q <= status_d;
            fault_q  <= fault_d;
            step_q   <= step_d;
        end
    end

    // Next-state logic and combinational control-word unpacking.
    always_comb begin
        phase_d    = phase_q;
        i_d        = i_q;
        state_d    = state_q;
        status_d   = status_q;
        fault_d    = fault_q;
        step_d     = step_q;
        write_ok_s = 1'b0;

        imem_req   = 1'b0;
        alu_en     = 1'b0;
        alu_bs     = 1'b0;
        rf_b_en    = 1'b0;
        rf_w       = 1'b0;
        ram_en     = 1'b0;
        ram_w      = 1'b0;
        pc_en      = 1'b0;
        pc_is      = 1'b0;
        status_ld  = 1'b0;
        alu_fs     = 5'b00000;
        rf_sa      = 5'b00000;
        rf_sb      = 5'b00000;
        rf_da      = 5'b00000;
        pc_fs      = 2'b00;
        K          = 64'h0000_0000_0000_0000;
        retire     = 1'b0;

        case (phase_q)
            PH_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    i_d     = imem_data;
                    state_d = 2'b00;
                    step_d  = '0;
                    phase_d = PH_EXEC;
                end else begin
                    phase_d = PH_FETCH;
                end
            end
            PH_EXEC: begin
                // Bus enables and fields pass through even while stalled.
                alu_en  = cw_s.alu_en;
                alu_bs  = cw_s.alu_bs;
                alu_fs  = cw_s.alu_fs;
                rf_b_en = cw_s.rf_b_en;
                rf_sa   = cw_s.rf_sa;
                rf_sb   = cw_s.rf_sb;
                rf_da   = cw_s.rf_da;
                ram_en  = cw_s.ram_en;
                pc_fs   = cw_s.pc_fs;
                pc_is   = cw_s.pc_is;
                K       = K_in;
                if (stall) begin
                    write_ok_s = 1'b0;
                end else if (cw_s.next_state == 2'b00) begin
                    write_ok_s = 1'b1;
                    retire     = 1'b1;
                    state_d    = 2'b00;
                    phase_d    = PH_FETCH;
                end else if (step_q == LAST_STEP) begin
                    write_ok_s = 1'b0;
                    fault_d    = 1'b1;
                    phase_d    = PH_HALT;
                end else begin
                    write_ok_s = 1'b1;
                    state_d    = cw_s.next_state;
                    step_d     = step_q + SW'(1);
                end
                rf_w      = cw_s.rf_w      & write_ok_s;
                ram_w     = cw_s.ram_w     & write_ok_s;
                pc_en     = cw_s.pc_en     & write_ok_s;
                status_ld = cw_s.status_ld & write_ok_s;
                if (status_ld) begin
                    status_d = alu_flags;
                end else begin
                    status_d = status_q;
                end
            end
            PH_HALT: begin
                phase_d = PH_HALT;
            end
            default: begin
                phase_d = PH_FETCH;
            end
        endcase
    end

    assign I      = i_q;
    assign state  = state_q;
    assign status = status_q;
    assign fault  = fault_q;

endmodule
